// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state, field and key definitions for the digital clock
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_SET_H = 2'd1,
      ST_SET_M = 2'd2,
      ST_SET_S = 2'd3
   } state_t;

   localparam logic [1:0] FLD_NONE = 2'd0;
   localparam logic [1:0] FLD_HOUR = 2'd1;
   localparam logic [1:0] FLD_MIN  = 2'd2;
   localparam logic [1:0] FLD_SEC  = 2'd3;

   localparam int KEY_MODE = 0;
   localparam int KEY_UP   = 1;
   localparam int KEY_DOWN = 2;
   localparam int KEY_OK   = 3;

   function automatic logic [1:0] field_of(state_t s);
      case (s)
         ST_SET_H: return FLD_HOUR;
         ST_SET_M: return FLD_MIN;
         ST_SET_S: return FLD_SEC;
         default:  return FLD_NONE;
      endcase
   endfunction

   function automatic logic [5:0] digit_mask(logic [1:0] f);
      case (f)
         FLD_HOUR: return 6'b110000;
         FLD_MIN:  return 6'b001100;
         FLD_SEC:  return 6'b000011;
         default:  return 6'b000000;
      endcase
   endfunction

   function automatic logic [3:0] state_onehot(state_t s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - press edge and hold/auto-repeat timer for one active-low key
module key_repeat #(
   parameter int DLY_MS  = 500,
   parameter int RATE_MS = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   input  logic tick,
   input  logic clr,
   output logic press,
   output logic rpt
);
   localparam int CW = $clog2(DLY_MS + RATE_MS + 1);
   localparam logic [CW-1:0] DLY_LIM = CW'(DLY_MS);
   localparam logic [CW-1:0] RPT_LIM = CW'(DLY_MS + RATE_MS);

   logic          key_q;
   logic          armed;
   logic [CW-1:0] ms_cnt;
   logic [CW-1:0] ms_inc;

   // key_q clears to "held" so a key held through reset never looks like a fresh press
   assign press  = key_q & ~key;
   assign ms_inc = ms_cnt + 1'b1;
   assign rpt    = armed & ~key & ~clr & tick & ((ms_inc == DLY_LIM) || (ms_inc == RPT_LIM));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q  <= 1'b0;
         armed  <= 1'b0;
         ms_cnt <= '0;
      end else begin
         key_q <= key;
         if (key) begin
            armed  <= 1'b0;
            ms_cnt <= '0;
         end else if (press) begin
            armed  <= 1'b1;
            ms_cnt <= '0;
         end else if (clr || !armed) begin
            ms_cnt <= '0;
         end else if (tick) begin
            ms_cnt <= (ms_inc == RPT_LIM) ? DLY_LIM : ms_inc;
         end
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-set mode sequencer with inc/dec commands and digit blink mask
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TICKS_PER_MS   = 50000,
   parameter int BLINK_HALF_MS  = 250,
   parameter int TIMEOUT_MS     = 10000,
   parameter int REPEAT_DLY_MS  = 500,
   parameter int REPEAT_RATE_MS = 100
) (
   input  logic       CLK_50M,
   input  logic       RST_N,
   input  logic [7:0] key_out,
   output logic       run_en,
   output logic [1:0] field_sel,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic [5:0] blink_mask,
   output logic [3:0] state_led
);
   localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam int IW = $clog2(TIMEOUT_MS + 1);
   localparam int BW = $clog2(BLINK_HALF_MS + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_MS - 1);
   localparam logic [IW-1:0] IDLE_LIM  = IW'(TIMEOUT_MS);
   localparam logic [BW-1:0] BLINK_LIM = BW'(BLINK_HALF_MS);

   state_t        state, state_nxt;
   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic          mode_q, ok_q;
   logic          mode_p, ok_p, up_p, dn_p, up_rpt, dn_rpt;
   logic          any_press, both_low, adj_held, in_set, change, timeout, adj_ok;
   logic [IW-1:0] idle_cnt;
   logic [BW-1:0] blink_cnt, blink_cnt_nxt;
   logic          phase, phase_nxt;
   logic [5:0]    mask_nxt;
   logic          unused_keys;

   assign unused_keys = &key_out[7:4];

   assign tick      = (pre_cnt == PRE_LAST);
   assign mode_p    = mode_q & ~key_out[KEY_MODE];
   assign ok_p      = ok_q & ~key_out[KEY_OK];
   assign any_press = mode_p | ok_p | up_p | dn_p;
   assign both_low  = ~key_out[KEY_UP] & ~key_out[KEY_DOWN];
   assign adj_held  = ~key_out[KEY_UP] | ~key_out[KEY_DOWN];
   assign in_set    = (state != ST_RUN);
   assign timeout   = in_set & tick & ~any_press & ((idle_cnt + 1'b1) == IDLE_LIM);

   key_repeat #(.DLY_MS(REPEAT_DLY_MS), .RATE_MS(REPEAT_RATE_MS)) u_up (
      .clk   (CLK_50M),
      .rst_n (RST_N),
      .key   (key_out[KEY_UP]),
      .tick  (tick),
      .clr   (both_low),
      .press (up_p),
      .rpt   (up_rpt)
   );

   key_repeat #(.DLY_MS(REPEAT_DLY_MS), .RATE_MS(REPEAT_RATE_MS)) u_down (
      .clk   (CLK_50M),
      .rst_n (RST_N),
      .key   (key_out[KEY_DOWN]),
      .tick  (tick),
      .clr   (both_low),
      .press (dn_p),
      .rpt   (dn_rpt)
   );

   // OK beats MODE, and any state change swallows a coincident UP/DOWN event
   always_comb begin
      state_nxt = state;
      if (in_set && ok_p) begin
         state_nxt = ST_RUN;
      end else if (mode_p) begin
         case (state)
            ST_RUN:   state_nxt = ST_SET_H;
            ST_SET_H: state_nxt = ST_SET_M;
            ST_SET_M: state_nxt = ST_SET_S;
            default:  state_nxt = ST_RUN;
         endcase
      end else if (timeout) begin
         state_nxt = ST_RUN;
      end
   end

   assign change = (state_nxt != state);
   assign adj_ok = in_set & ~change & ~both_low;

   always_comb begin
      blink_cnt_nxt = blink_cnt;
      phase_nxt     = phase;
      if (change) begin
         blink_cnt_nxt = '0;
         phase_nxt     = 1'b0;
      end else if (tick) begin
         if ((blink_cnt + 1'b1) == BLINK_LIM) begin
            blink_cnt_nxt = '0;
            phase_nxt     = ~phase;
         end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      mask_nxt = 6'b000000;
      if ((state_nxt != ST_RUN) && phase_nxt && !adj_held)
         mask_nxt = digit_mask(field_of(state_nxt));
   end

   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         state      <= ST_RUN;
         pre_cnt    <= '0;
         mode_q     <= 1'b0;
         ok_q       <= 1'b0;
         idle_cnt   <= '0;
         blink_cnt  <= '0;
         phase      <= 1'b0;
         inc_pulse  <= 1'b0;
         dec_pulse  <= 1'b0;
         blink_mask <= 6'b000000;
      end else begin
         state     <= state_nxt;
         pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
         mode_q    <= key_out[KEY_MODE];
         ok_q      <= key_out[KEY_OK];
         blink_cnt <= blink_cnt_nxt;
         phase     <= phase_nxt;
         if (change || any_press || !in_set)
            idle_cnt <= '0;
         else if (tick)
            idle_cnt <= idle_cnt + 1'b1;
         inc_pulse  <= adj_ok & (up_p | up_rpt);
         dec_pulse  <= adj_ok & (dn_p | dn_rpt);
         blink_mask <= mask_nxt;
      end
   end

   assign run_en    = (state == ST_RUN);
   assign field_sel = field_of(state);
   assign state_led = state_onehot(state);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed table and sequence bench for clock_set_ctrl
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] key_out = 8'hFF;
   logic       run_en, inc_pulse, dec_pulse;
   logic [1:0] field_sel;
   logic [5:0] blink_mask;
   logic [3:0] state_led;

   int total = 0;
   int bad = 0;
   int cyc;

   typedef struct {
      logic [7:0] key;
      logic [3:0] led;
      logic [1:0] fs;
      logic       run;
      logic       inc;
      logic       dec;
      logic [5:0] mask;
   } vec_t;

   vec_t vecs[18];

   clock_set_ctrl #(
      .TICKS_PER_MS(4), .BLINK_HALF_MS(2), .TIMEOUT_MS(20),
      .REPEAT_DLY_MS(5), .REPEAT_RATE_MS(2)
   ) dut (
      .CLK_50M   (clk),
      .RST_N     (rst_n),
      .key_out   (key_out),
      .run_en    (run_en),
      .field_sel (field_sel),
      .inc_pulse (inc_pulse),
      .dec_pulse (dec_pulse),
      .blink_mask(blink_mask),
      .state_led (state_led)
   );

   always #5 clk = ~clk;

   // mirrors the ms prescaler phase: cycles since reset release, mod 4
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic press(input logic [7:0] k);
      @(negedge clk);
      key_out = k;
      @(negedge clk);
      key_out = 8'hFF;
   endtask

   task automatic align;
      @(negedge clk);
      while (cyc % 4 != 0) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_led"},  {4'd0, state_led}, 8'h01);
      chk({tag, "_run"},  {7'd0, run_en},    8'h01);
      chk({tag, "_fs"},   {6'd0, field_sel}, 8'h00);
      chk({tag, "_inc"},  {7'd0, inc_pulse}, 8'h00);
      chk({tag, "_dec"},  {7'd0, dec_pulse}, 8'h00);
      chk({tag, "_mask"}, {2'd0, blink_mask}, 8'h00);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{8'hFE, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[1]  = '{8'hFD, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0, 6'd0};
      vecs[2]  = '{8'hFE, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[3]  = '{8'hFB, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1, 6'd0};
      vecs[4]  = '{8'hFE, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[5]  = '{8'hFE, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0};
      vecs[6]  = '{8'hF7, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0};
      vecs[7]  = '{8'hFD, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0};
      vecs[8]  = '{8'hFE, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[9]  = '{8'hF7, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0};
      vecs[10] = '{8'hFE, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[11] = '{8'hF6, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0};
      vecs[12] = '{8'hFE, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[13] = '{8'hFE, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[14] = '{8'hFE, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[15] = '{8'hFC, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0};
      vecs[16] = '{8'hFE, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 6'd0};
      vecs[17] = '{8'hF3, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0};

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         key_out = vecs[i].key;
         @(negedge clk);
         key_out = 8'hFF;
         chk($sformatf("vec%0d_led", i),  {4'd0, state_led},  {4'd0, vecs[i].led});
         chk($sformatf("vec%0d_fs", i),   {6'd0, field_sel},  {6'd0, vecs[i].fs});
         chk($sformatf("vec%0d_run", i),  {7'd0, run_en},     {7'd0, vecs[i].run});
         chk($sformatf("vec%0d_inc", i),  {7'd0, inc_pulse},  {7'd0, vecs[i].inc});
         chk($sformatf("vec%0d_dec", i),  {7'd0, dec_pulse},  {7'd0, vecs[i].dec});
         chk($sformatf("vec%0d_mask", i), {2'd0, blink_mask}, {2'd0, vecs[i].mask});
      end

      // UP held 13 ms in SET_M: press pulse, then repeats at 5,7,9,11,13 ms
      press(8'hFE);
      press(8'hFE);
      align();
      key_out = 8'hFD;
      for (int e = 1; e <= 60; e++) begin
         logic exp_inc;
         @(negedge clk);
         exp_inc = (e == 1) || (e == 20) || (e == 28) || (e == 36) || (e == 44) || (e == 52);
         chk($sformatf("rpt_inc_e%0d", e), {7'd0, inc_pulse}, {7'd0, exp_inc});
         chk($sformatf("rpt_dec_e%0d", e), {7'd0, dec_pulse}, 8'h00);
         if (e <= 52) chk($sformatf("rpt_mask_e%0d", e), {2'd0, blink_mask}, 8'h00);
         if (e == 52) key_out = 8'hFF;
      end
      chk("rpt_fs_after", {6'd0, field_sel}, 8'h02);
      press(8'hF7);

      // SET_H idle: blink every 8 cycles, timeout to RUN at 20 ms
      align();
      key_out = 8'hFE;
      for (int e = 1; e <= 84; e++) begin
         logic [5:0] exp_mask;
         @(negedge clk);
         if (e == 1) key_out = 8'hFF;
         exp_mask = (e >= 8 && e < 80 && ((e / 8) % 2 == 1)) ? 6'b110000 : 6'b000000;
         chk($sformatf("blink_mask_e%0d", e), {2'd0, blink_mask}, {2'd0, exp_mask});
         chk($sformatf("blink_fs_e%0d", e), {6'd0, field_sel}, (e < 80) ? 8'h01 : 8'h00);
      end
      chk("timeout_run", {7'd0, run_en}, 8'h01);

      // UP and DOWN low together in SET_M
      press(8'hFE);
      press(8'hFE);
      @(negedge clk);
      key_out = 8'hF9;
      for (int e = 1; e <= 44; e++) begin
         @(negedge clk);
         chk($sformatf("both_inc_e%0d", e), {7'd0, inc_pulse}, 8'h00);
         chk($sformatf("both_dec_e%0d", e), {7'd0, dec_pulse}, 8'h00);
      end
      key_out = 8'hFF;
      chk("both_fs", {6'd0, field_sel}, 8'h02);
      press(8'hF7);

      // reset asserted mid-repeat, UP still held afterwards
      press(8'hFE);
      press(8'hFE);
      @(negedge clk);
      key_out = 8'hFD;
      repeat (30) @(negedge clk);
      chk("midrpt_fs", {6'd0, field_sel}, 8'h02);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 60; e++) begin
         @(negedge clk);
         chk($sformatf("post_rst_inc_e%0d", e), {7'd0, inc_pulse}, 8'h00);
         chk($sformatf("post_rst_led_e%0d", e), {4'd0, state_led}, 8'h01);
      end
      key_out = 8'hFF;
      press(8'hFE);
      chk("post_rst_mode", {6'd0, field_sel}, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
